square_draw_ctrl: RTL and testbench

- Initiator-side sequencer for the 4x4 square plotter datapath. It accepts square-draw requests over a valid/ready handshake.
- For each request it presents the plot coordinates and colour, clears and steps the plotter's pixel counters, and waits for the plotter's last-pixel indication.
- Optional "move" requests first erase the previously drawn square in background colour. This is the basis of block motion in the stacker game.
- Sits between the game FSM and the plotter/VGA adapter.

---
 rtl/square_draw_pkg.sv | 35 +++
 rtl/draw_watchdog.sv | 49 ++++
 rtl/square_draw_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_square_draw_ctrl.sv | 398 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/square_draw_pkg.sv
// ---------------------------------------------------------------------------
// square_draw_pkg
// Shared definitions for the square-draw sequencer:
//   - default widths for coordinates and colour
//   - default erase colour and watchdog limit
//   - sequencer state encoding and small state-decode helpers
// ---------------------------------------------------------------------------
package square_draw_pkg;

   localparam int X_W_DEF            = 8;
   localparam int Y_W_DEF            = 7;
   localparam int C_W_DEF            = 3;
   localparam int BG_COLOUR_DEF      = 0;
   localparam int TIMEOUT_CYCLES_DEF = 64;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_PREP_ERASE = 3'd1,
      ST_ERASE      = 3'd2,
      ST_PREP_DRAW  = 3'd3,
      ST_DRAW       = 3'd4,
      ST_FINISH     = 3'd5
   } draw_state_e;

   // States that hold the plotter's pixel counters in clear.
   function automatic logic state_is_prep(input draw_state_e s);
      return (s == ST_PREP_ERASE) || (s == ST_PREP_DRAW);
   endfunction

   // States that step the plotter and write the framebuffer.
   function automatic logic state_is_plot(input draw_state_e s);
      return (s == ST_ERASE) || (s == ST_DRAW);
   endfunction

endpackage

// File: rtl/draw_watchdog.sv
// ---------------------------------------------------------------------------
// draw_watchdog
// Cycle counter guarding one ERASE or DRAW phase.
//   clk     : system clock
//   resetn  : asynchronous active-low reset
//   clr     : restart the count (asserted in the PREP states)
//   cnt_en  : count this cycle (asserted while plotting)
//   expire  : this enabled cycle is the TIMEOUT_CYCLES-th of the phase
// ---------------------------------------------------------------------------
module draw_watchdog
   import square_draw_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic clk,
   input  logic resetn,
   input  logic clr,
   input  logic cnt_en,
   output logic expire
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // cnt_q counts completed cycles of the phase, so the current cycle is
   // number cnt_q+1; expire flags the cycle that reaches the limit so the
   // sequencer leaves the phase on that very edge.
   assign expire = cnt_en && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (cnt_en && !expire) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/square_draw_ctrl.sv
// ---------------------------------------------------------------------------
// square_draw_ctrl
// Initiator-side sequencer for the 4x4 square plotter. Accepts one
// square-draw request at a time over valid/ready, optionally erases the
// previously drawn square in the background colour, then draws the new one.
//
// Ports:
//   clk, resetn               : clock, asynchronous active-low reset
//   req_valid / req_ready     : request handshake
//   req_x, req_y, req_colour  : square origin and fill colour
//   req_move                  : erase the previous square first
//   plot_x, plot_y            : origin presented to the plotter
//   plot_colour               : colour presented to the plotter
//   plot_clr_n                : synchronous active-low clear of plotter counters
//   plot_en                   : plotter advance / framebuffer write enable
//   plot_done                 : plotter presenting its 16th pixel
//   busy                      : request in progress
//   done_pulse                : one-cycle completion strobe
//   err_timeout               : sticky watchdog abort flag
// ---------------------------------------------------------------------------
module square_draw_ctrl
   import square_draw_pkg::*;
#(
   parameter int X_W            = X_W_DEF,
   parameter int Y_W            = Y_W_DEF,
   parameter int C_W            = C_W_DEF,
   parameter int BG_COLOUR      = BG_COLOUR_DEF,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic           clk,
   input  logic           resetn,
   input  logic           req_valid,
   output logic           req_ready,
   input  logic [X_W-1:0] req_x,
   input  logic [Y_W-1:0] req_y,
   input  logic [C_W-1:0] req_colour,
   input  logic           req_move,
   output logic [X_W-1:0] plot_x,
   output logic [Y_W-1:0] plot_y,
   output logic [C_W-1:0] plot_colour,
   output logic           plot_clr_n,
   output logic           plot_en,
   input  logic           plot_done,
   output logic           busy,
   output logic           done_pulse,
   output logic           err_timeout
);

   draw_state_e    state_q, state_d;
   logic           rst_done_q, rst_done_d;
   logic           have_prev_q, have_prev_d;
   logic           err_q, err_d;
   logic [X_W-1:0] prev_x_q, prev_x_d;
   logic [Y_W-1:0] prev_y_q, prev_y_d;
   logic [X_W-1:0] cap_x_q, cap_x_d;
   logic [Y_W-1:0] cap_y_q, cap_y_d;
   logic [C_W-1:0] cap_colour_q, cap_colour_d;
   logic [X_W-1:0] plot_x_q, plot_x_d;
   logic [Y_W-1:0] plot_y_q, plot_y_d;
   logic [C_W-1:0] plot_colour_q, plot_colour_d;

   logic           xfer;
   logic           wd_clr;
   logic           wd_en;
   logic           wd_expire;

   // Ready is withheld for the first cycle after reset release so the
   // requester never sees a handshake coincide with reset deassertion.
   assign rst_done_d = 1'b1;
   assign req_ready  = rst_done_q && (state_q == ST_IDLE);
   assign xfer       = req_valid && req_ready;

   assign wd_clr = state_is_prep(state_q);
   assign wd_en  = state_is_plot(state_q);

   draw_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk    (clk),
      .resetn (resetn),
      .clr    (wd_clr),
      .cnt_en (wd_en),
      .expire (wd_expire)
   );

   // ------------------------------------------------------------------
   // Next-state and datapath. The plot_* registers are loaded on the edge
   // that enters a PREP state, so they are already stable while the
   // plotter counters are being cleared and stay stable for the phase.
   // ------------------------------------------------------------------
   always_comb begin
      state_d       = state_q;
      have_prev_d   = have_prev_q;
      err_d         = err_q;
      prev_x_d      = prev_x_q;
      prev_y_d      = prev_y_q;
      cap_x_d       = cap_x_q;
      cap_y_d       = cap_y_q;
      cap_colour_d  = cap_colour_q;
      plot_x_d      = plot_x_q;
      plot_y_d      = plot_y_q;
      plot_colour_d = plot_colour_q;

      case (state_q)
         ST_IDLE: begin
            if (xfer) begin
               cap_x_d      = req_x;
               cap_y_d      = req_y;
               cap_colour_d = req_colour;
               // A move with nothing on screen yet degenerates to a draw.
               if (req_move && have_prev_q) begin
                  state_d       = ST_PREP_ERASE;
                  plot_x_d      = prev_x_q;
                  plot_y_d      = prev_y_q;
                  plot_colour_d = C_W'(BG_COLOUR);
               end else begin
                  state_d       = ST_PREP_DRAW;
                  plot_x_d      = req_x;
                  plot_y_d      = req_y;
                  plot_colour_d = req_colour;
               end
            end
         end

         ST_PREP_ERASE: begin
            state_d = ST_ERASE;
         end

         ST_ERASE: begin
            // The last pixel is written in the cycle plot_done is seen,
            // so completion takes priority over a coincident timeout.
            if (plot_done) begin
               state_d       = ST_PREP_DRAW;
               plot_x_d      = cap_x_q;
               plot_y_d      = cap_y_q;
               plot_colour_d = cap_colour_q;
            end else if (wd_expire) begin
               state_d = ST_IDLE;
               err_d   = 1'b1;
            end
         end

         ST_PREP_DRAW: begin
            state_d = ST_DRAW;
         end

         ST_DRAW: begin
            if (plot_done) begin
               state_d = ST_FINISH;
            end else if (wd_expire) begin
               state_d = ST_IDLE;
               err_d   = 1'b1;
            end
         end

         ST_FINISH: begin
            // Only a completed draw becomes the square to erase next time;
            // an aborted one leaves the previous record untouched.
            prev_x_d    = cap_x_q;
            prev_y_d    = cap_y_q;
            have_prev_d = 1'b1;
            state_d     = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q       <= ST_IDLE;
         rst_done_q    <= 1'b0;
         have_prev_q   <= 1'b0;
         err_q         <= 1'b0;
         prev_x_q      <= '0;
         prev_y_q      <= '0;
         cap_x_q       <= '0;
         cap_y_q       <= '0;
         cap_colour_q  <= '0;
         plot_x_q      <= '0;
         plot_y_q      <= '0;
         plot_colour_q <= '0;
      end else begin
         state_q       <= state_d;
         rst_done_q    <= rst_done_d;
         have_prev_q   <= have_prev_d;
         err_q         <= err_d;
         prev_x_q      <= prev_x_d;
         prev_y_q      <= prev_y_d;
         cap_x_q       <= cap_x_d;
         cap_y_q       <= cap_y_d;
         cap_colour_q  <= cap_colour_d;
         plot_x_q      <= plot_x_d;
         plot_y_q      <= plot_y_d;
         plot_colour_q <= plot_colour_d;
      end
   end

   // ------------------------------------------------------------------
   // Moore outputs. Gating the clear with rst_done_q keeps the plotter
   // counters held clear throughout reset and the cycle after release.
   // ------------------------------------------------------------------
   assign plot_x      = plot_x_q;
   assign plot_y      = plot_y_q;
   assign plot_colour = plot_colour_q;
   assign plot_clr_n  = rst_done_q && !state_is_prep(state_q);
   assign plot_en     = state_is_plot(state_q);
   assign busy        = (state_q != ST_IDLE);
   assign done_pulse  = (state_q == ST_FINISH);
   assign err_timeout = err_q;

endmodule

// File: tb/tb_square_draw_ctrl.sv
module tb_square_draw_ctrl;

   logic       clk = 1'b0;
   logic       resetn;
   logic       req_valid;
   logic       req_ready;
   logic [7:0] req_x;
   logic [6:0] req_y;
   logic [2:0] req_colour;
   logic       req_move;
   logic [7:0] plot_x;
   logic [6:0] plot_y;
   logic [2:0] plot_colour;
   logic       plot_clr_n;
   logic       plot_en;
   logic       plot_done;
   logic       busy;
   logic       done_pulse;
   logic       err_timeout;

   always #5 clk = ~clk;

   square_draw_ctrl dut (
      .clk         (clk),
      .resetn      (resetn),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_x       (req_x),
      .req_y       (req_y),
      .req_colour  (req_colour),
      .req_move    (req_move),
      .plot_x      (plot_x),
      .plot_y      (plot_y),
      .plot_colour (plot_colour),
      .plot_clr_n  (plot_clr_n),
      .plot_en     (plot_en),
      .plot_done   (plot_done),
      .busy        (busy),
      .done_pulse  (done_pulse),
      .err_timeout (err_timeout)
   );

   // Behavioural 4x4 plotter: pixel counter, cleared synchronously,
   // advanced on plot_en; done while presenting pixel 15.
   logic [3:0] pcnt = 4'd0;
   logic       stuck_done = 1'b0;
   always @(posedge clk) begin
      if (!plot_clr_n)  pcnt <= 4'd0;
      else if (plot_en) pcnt <= pcnt + 4'd1;
   end
   assign plot_done = (pcnt == 4'd15) && !stuck_done;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int vectors = 0;
   int miscompares = 0;

   // Scoreboard of expected framebuffer writes {x, y, colour}.
   logic [17:0] sb[$];

   // Reference model of "previous square" bookkeeping.
   bit         m_have_prev = 1'b0;
   logic [7:0] m_px = 8'd0;
   logic [6:0] m_py = 7'd0;
   bit         pend_valid = 1'b0;
   logic [7:0] pend_x = 8'd0;
   logic [6:0] pend_y = 7'd0;

   int done_cnt = 0;
   int last_done_cyc = -1;
   int last_rise_cyc = -1;
   int last_en_cyc = -1;
   bit en_prev = 1'b0;

   // Advance to the next falling edge and observe the DUT there.
   task automatic tick();
      logic [17:0] obs;
      logic [17:0] exp_w;
      @(negedge clk);
      if (plot_en === 1'b1) begin
         if (!en_prev) last_rise_cyc = cyc;
         last_en_cyc = cyc;
         obs = {plot_x + {6'd0, pcnt[1:0]}, plot_y + {5'd0, pcnt[3:2]}, plot_colour};
         vectors++;
         if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL write: got x=%0d y=%0d c=%0d required no write (cyc %0d)",
                     obs[17:10], obs[9:3], obs[2:0], cyc);
         end else begin
            exp_w = sb.pop_front();
            if (obs !== exp_w) begin
               miscompares++;
               $display("FAIL write: got x=%0d y=%0d c=%0d required x=%0d y=%0d c=%0d (cyc %0d)",
                        obs[17:10], obs[9:3], obs[2:0], exp_w[17:10], exp_w[9:3], exp_w[2:0], cyc);
            end
         end
      end
      en_prev = (plot_en === 1'b1);
      if (done_pulse === 1'b1) begin
         done_cnt++;
         last_done_cyc = cyc;
         if (pend_valid) begin
            m_have_prev = 1'b1;
            m_px = pend_x;
            m_py = pend_y;
            pend_valid = 1'b0;
         end
      end
   endtask

   // Present a request and wait (bounded) for it to be taken; pushes the
   // expected writes when the handshake is seen. t_xfer is the cycle whose
   // closing edge performs the transfer.
   task automatic send_req(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c,
                           input logic mv, input int n_draw, input bit hold, output int t_xfer);
      t_xfer = -1;
      req_valid = 1'b1;
      req_x = x;
      req_y = y;
      req_colour = c;
      req_move = mv;
      for (int k = 0; k < 300; k++) begin
         if (req_ready === 1'b1) begin
            t_xfer = cyc;
            break;
         end
         tick();
      end
      vectors++;
      if (t_xfer < 0) begin
         miscompares++;
         $display("FAIL accept: got no req_ready within 300 cycles required acceptance");
      end else begin
         if (mv && m_have_prev)
            for (int i = 0; i < 16; i++)
               sb.push_back({m_px + 8'(i % 4), m_py + 7'(i / 4), 3'd0});
         for (int i = 0; i < n_draw; i++)
            sb.push_back({x + 8'(i % 4), y + 7'((i / 4) % 4), c});
         pend_valid = 1'b1;
         pend_x = x;
         pend_y = y;
      end
      tick();
      if (!hold) req_valid = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit seen);
      int d0;
      d0 = done_cnt;
      seen = 1'b0;
      for (int k = 0; k < budget; k++) begin
         if (done_cnt != d0) begin
            seen = 1'b1;
            break;
         end
         tick();
      end
   endtask

   task automatic test_reset();
      logic [21:0] got;
      resetn = 1'b0;
      req_valid = 1'b0;
      req_x = 8'd0;
      req_y = 7'd0;
      req_colour = 3'd0;
      req_move = 1'b0;
      tick();
      tick();
      got = {plot_x, plot_y, plot_colour, plot_clr_n, plot_en, done_pulse, busy, req_ready, err_timeout};
      vectors++;
      if (got !== 22'd0) begin
         miscompares++;
         $display("FAIL reset_outputs: got %h required 000000", got);
      end
      resetn = 1'b1;
      vectors++;
      if (req_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL ready_at_release: got %b required 0", req_ready);
      end
      tick();
      vectors++;
      if (req_ready !== 1'b1 || plot_clr_n !== 1'b1) begin
         miscompares++;
         $display("FAIL ready_after_release: got ready=%b clr_n=%b required 1/1", req_ready, plot_clr_n);
      end
   endtask

   task automatic test_draw_only();
      int t;
      bit seen;
      send_req(8'd10, 7'd20, 3'd5, 1'b0, 16, 1'b0, t);
      wait_done(100, seen);
      vectors++;
      if (!seen || last_done_cyc != t + 18) begin
         miscompares++;
         $display("FAIL draw_done_time: got cyc %0d required %0d", last_done_cyc, t + 18);
      end
      vectors++;
      if (last_rise_cyc != t + 2 || last_en_cyc != t + 17) begin
         miscompares++;
         $display("FAIL draw_en_window: got %0d..%0d required %0d..%0d",
                  last_rise_cyc, last_en_cyc, t + 2, t + 17);
      end
      tick();
      vectors++;
      if (busy !== 1'b0 || req_ready !== 1'b1 || cyc != t + 19) begin
         miscompares++;
         $display("FAIL draw_idle: got busy=%b ready=%b cyc=%0d required 0/1 cyc %0d",
                  busy, req_ready, cyc, t + 19);
      end
      vectors++;
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL draw_writes_left: got %0d pending required 0", sb.size());
      end
   endtask

   task automatic test_move();
      int t;
      bit seen;
      send_req(8'd14, 7'd20, 3'd2, 1'b1, 16, 1'b0, t);
      wait_done(100, seen);
      vectors++;
      if (!seen || last_done_cyc != t + 35) begin
         miscompares++;
         $display("FAIL move_done_time: got cyc %0d required %0d", last_done_cyc, t + 35);
      end
      tick();
      vectors++;
      if (sb.size() != 0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL move_end: got pending=%0d busy=%b required 0/0", sb.size(), busy);
      end
   endtask

   task automatic test_back_to_back();
      int ta;
      int tb2;
      bit got;
      bit seen;
      send_req(8'd20, 7'd30, 3'd6, 1'b0, 16, 1'b1, ta);
      got = 1'b0;
      for (int k = 0; k < 100; k++) begin
         if (req_ready === 1'b1) begin
            got = 1'b1;
            break;
         end
         req_x = 8'($urandom);
         req_y = 7'($urandom);
         req_colour = 3'($urandom);
         req_move = 1'($urandom);
         tick();
      end
      vectors++;
      if (!got || last_done_cyc != ta + 18 || cyc != ta + 19) begin
         miscompares++;
         $display("FAIL held_first: got done %0d ready cyc %0d required %0d/%0d",
                  last_done_cyc, cyc, ta + 18, ta + 19);
      end
      send_req(8'd24, 7'd30, 3'd1, 1'b1, 16, 1'b0, tb2);
      vectors++;
      if (tb2 != ta + 19) begin
         miscompares++;
         $display("FAIL held_second_accept: got cyc %0d required %0d", tb2, ta + 19);
      end
      wait_done(100, seen);
      vectors++;
      if (!seen || last_done_cyc != tb2 + 35 || sb.size() != 0) begin
         miscompares++;
         $display("FAIL held_second_done: got cyc %0d pending %0d required %0d/0",
                  last_done_cyc, sb.size(), tb2 + 35);
      end
   endtask

   task automatic test_timeout();
      int t;
      int d0;
      stuck_done = 1'b1;
      d0 = done_cnt;
      send_req(8'd40, 7'd50, 3'd3, 1'b0, 64, 1'b0, t);
      if (t >= 0) begin
         for (int k = 0; k < 200 && cyc < t + 65; k++) tick();
         vectors++;
         if (err_timeout !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_early: got err=%b busy=%b required 0/1 at cyc %0d",
                     err_timeout, busy, cyc);
         end
         tick();
         vectors++;
         if (err_timeout !== 1'b1 || busy !== 1'b0 || plot_en !== 1'b0 || cyc != t + 66) begin
            miscompares++;
            $display("FAIL timeout_fire: got err=%b busy=%b en=%b cyc=%0d required 1/0/0 cyc %0d",
                     err_timeout, busy, plot_en, cyc, t + 66);
         end
      end
      for (int k = 0; k < 4; k++) tick();
      stuck_done = 1'b0;
      pend_valid = 1'b0;
      vectors++;
      if (done_cnt != d0 || sb.size() != 0) begin
         miscompares++;
         $display("FAIL timeout_nodone: got done count %0d pending %0d required %0d/0",
                  done_cnt, sb.size(), d0);
      end
   endtask

   task automatic test_sticky_err();
      int t;
      bit seen;
      send_req(8'd50, 7'd40, 3'd4, 1'b1, 16, 1'b0, t);
      wait_done(100, seen);
      vectors++;
      if (!seen || last_done_cyc != t + 35 || err_timeout !== 1'b1) begin
         miscompares++;
         $display("FAIL sticky_err: got done %0d err=%b required %0d/1",
                  last_done_cyc, err_timeout, t + 35);
      end
      tick();
      vectors++;
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL sticky_writes_left: got %0d required 0", sb.size());
      end
   endtask

   task automatic test_reset_mid_draw();
      int t;
      bit hit;
      bit seen;
      logic [21:0] got;
      send_req(8'd60, 7'd10, 3'd7, 1'b1, 16, 1'b0, t);
      hit = 1'b0;
      for (int k = 0; k < 80; k++) begin
         if (plot_en === 1'b1 && plot_colour === 3'd7 && pcnt == 4'd6) begin
            hit = 1'b1;
            break;
         end
         tick();
      end
      vectors++;
      if (!hit || cyc != t + 25) begin
         miscompares++;
         $display("FAIL pixel7_time: got cyc %0d required %0d", cyc, t + 25);
      end
      #2 resetn = 1'b0;
      #1;
      got = {plot_x, plot_y, plot_colour, plot_clr_n, plot_en, done_pulse, busy, req_ready, err_timeout};
      vectors++;
      if (got !== 22'd0) begin
         miscompares++;
         $display("FAIL async_reset: got %h required 000000", got);
      end
      sb.delete();
      pend_valid = 1'b0;
      m_have_prev = 1'b0;
      tick();
      tick();
      resetn = 1'b1;
      tick();
      send_req(8'd70, 7'd5, 3'd2, 1'b1, 16, 1'b0, t);
      wait_done(100, seen);
      vectors++;
      if (!seen || last_done_cyc != t + 18 || last_rise_cyc != t + 2) begin
         miscompares++;
         $display("FAIL move_after_reset: got done %0d first en %0d required %0d/%0d",
                  last_done_cyc, last_rise_cyc, t + 18, t + 2);
      end
      tick();
      vectors++;
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL move_after_reset_writes: got %0d pending required 0", sb.size());
      end
   endtask

   initial begin
      test_reset();
      test_draw_only();
      test_move();
      test_back_to_back();
      test_timeout();
      test_sticky_err();
      test_reset_mid_draw();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_time_limit: got no completion required finish before 200000");
      $fatal(1, "time limit");
   end

endmodule
